// File: rtl/cache_set_assoc.sv
// Set-associative cache tag/state controller (tags + metadata only, no data array).
// Optional statistics counters are enabled by defining CACHE_SET_ASSOC_STATS_EN.
module cache_set_assoc #(
  parameter int unsigned ADDR_W      = 48,
  parameter int unsigned BLOCK_BYTES = 64,
  parameter int unsigned SETS        = 32,
  parameter int unsigned WAYS        = 4,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned OFF_W      = $clog2(BLOCK_BYTES),
  localparam int unsigned IDX_W      = $clog2(SETS),
  localparam int unsigned TAG_W      = ADDR_W - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_policy,
  input  logic              replace_policy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_evict,
  output logic [ADDR_W-1:0] resp_evict_addr,
  output logic [TAG_W-1:0]  curr_tag,
  output logic [CNT_W-1:0]  num_reads,
  output logic [CNT_W-1:0]  num_writes,
  output logic [CNT_W-1:0]  num_hits,
  output logic [CNT_W-1:0]  num_misses,
  output logic [CNT_W-1:0]  num_writebacks
);

  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned LINE_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

  state_e              state_q;
  logic                we_q;
  logic                wp_q;
  logic                rp_q;
  logic [LINE_W-1:0]   line_q;
  logic [WAY_W-1:0]    way_q;
  logic                fill_q;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [WAYS-1:0]     dirty_q [SETS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [WAY_W-1:0]    age_q   [SETS][WAYS];
  logic [WAY_W-1:0]    fifo_q  [SETS];

  logic                accept;
  logic [IDX_W-1:0]    set_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                inv_found;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    lru_way;
  logic [WAY_W-1:0]    victim;
  logic                fill;
  logic                victim_dirty;
  logic                unused_offset;

  assign unused_offset = ^req_addr[OFF_W-1:0];
  assign req_ready     = (state_q == StIdle) && reset;
  assign accept        = req_valid && req_ready;
  assign set_idx       = line_q[IDX_W-1:0];
  assign req_tag       = line_q[LINE_W-1:IDX_W];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[set_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[set_idx][w] == WAY_W'(WAYS - 1)) begin
        lru_way = WAY_W'(w);
      end
    end
  end

  assign victim       = inv_found ? inv_way : (rp_q ? fifo_q[set_idx] : lru_way);
  // A write-through write miss allocates nothing.
  assign fill         = !hit && !(we_q && wp_q);
  assign victim_dirty = valid_q[set_idx][victim] && dirty_q[set_idx][victim];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= StIdle;
      we_q            <= 1'b0;
      wp_q            <= 1'b0;
      rp_q            <= 1'b0;
      line_q          <= '0;
      way_q           <= '0;
      fill_q          <= 1'b0;
      curr_tag        <= '0;
      resp_valid      <= 1'b0;
      resp_hit        <= 1'b0;
      resp_evict      <= 1'b0;
      resp_evict_addr <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q  <= StLookup;
            we_q     <= req_we;
            wp_q     <= write_policy;
            rp_q     <= replace_policy;
            line_q   <= req_addr[ADDR_W-1:OFF_W];
            curr_tag <= req_addr[ADDR_W-1:OFF_W+IDX_W];
          end
        end
        StLookup: begin
          state_q         <= StResp;
          way_q           <= hit ? hit_way : victim;
          fill_q          <= fill;
          resp_valid      <= 1'b1;
          resp_hit        <= hit;
          resp_evict      <= fill && victim_dirty;
          resp_evict_addr <= (fill && victim_dirty) ?
                             {tag_q[set_idx][victim], set_idx, {OFF_W{1'b0}}} : '0;
        end
        StResp: begin
          state_q         <= StIdle;
          resp_valid      <= 1'b0;
          resp_hit        <= 1'b0;
          resp_evict      <= 1'b0;
          resp_evict_addr <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Line and replacement state commit at the end of the response cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        fifo_q[s]  <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (state_q == StResp) begin
      if (resp_hit || fill_q) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          if (age_q[set_idx][w] < age_q[set_idx][way_q]) begin
            age_q[set_idx][w] <= age_q[set_idx][w] + WAY_W'(1);
          end
        end
        age_q[set_idx][way_q] <= '0;
      end
      if (fill_q) begin
        valid_q[set_idx][way_q] <= 1'b1;
        dirty_q[set_idx][way_q] <= we_q;
        tag_q[set_idx][way_q]   <= req_tag;
        fifo_q[set_idx]         <= fifo_q[set_idx] + WAY_W'(1);
      end else if (resp_hit && we_q && !wp_q) begin
        dirty_q[set_idx][way_q] <= 1'b1;
      end
    end
  end

`ifdef CACHE_SET_ASSOC_STATS_EN
  logic [CNT_W-1:0] reads_q, writes_q, hits_q, misses_q, wbs_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      reads_q  <= '0;
      writes_q <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      if (accept && !req_we && (reads_q != '1)) reads_q <= reads_q + CNT_W'(1);
      if (accept && req_we && (writes_q != '1)) writes_q <= writes_q + CNT_W'(1);
      if (state_q == StResp) begin
        if (resp_hit && (hits_q != '1)) hits_q <= hits_q + CNT_W'(1);
        if (!resp_hit && (misses_q != '1)) misses_q <= misses_q + CNT_W'(1);
        if (resp_evict && (wbs_q != '1)) wbs_q <= wbs_q + CNT_W'(1);
      end
    end
  end

  assign num_reads      = reads_q;
  assign num_writes     = writes_q;
  assign num_hits       = hits_q;
  assign num_misses     = misses_q;
  assign num_writebacks = wbs_q;
`else
  assign num_reads      = '0;
  assign num_writes     = '0;
  assign num_hits       = '0;
  assign num_misses     = '0;
  assign num_writebacks = '0;
`endif

endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed self-checking bench for cache_set_assoc at default parameters.
module tb_cache_set_assoc;

  localparam logic [47:0] BaseA  = 48'h7fff_4938_22b0;
  localparam logic [47:0] Stride = 48'h800;
`ifdef CACHE_SET_ASSOC_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        write_policy;
  logic        replace_policy;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [47:0] req_addr;
  logic        resp_valid;
  logic        resp_hit;
  logic        resp_evict;
  logic [47:0] resp_evict_addr;
  logic [36:0] curr_tag;
  logic [31:0] num_reads, num_writes, num_hits, num_misses, num_writebacks;

  int checks = 0;
  int errors = 0;

  cache_set_assoc dut (
    .clk             (clk),
    .reset           (reset),
    .write_policy    (write_policy),
    .replace_policy  (replace_policy),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .resp_valid      (resp_valid),
    .resp_hit        (resp_hit),
    .resp_evict      (resp_evict),
    .resp_evict_addr (resp_evict_addr),
    .curr_tag        (curr_tag),
    .num_reads       (num_reads),
    .num_writes      (num_writes),
    .num_hits        (num_hits),
    .num_misses      (num_misses),
    .num_writebacks  (num_writebacks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ex(input int v);
    return Stats ? 32'(v) : 32'd0;
  endfunction

  function automatic logic [47:0] ak(input int k);
    return BaseA + Stride * 48'(k);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Issues one request from a negedge; returns at the negedge of cycle N+3.
  task automatic do_req(input logic we, input logic [47:0] addr, input bit flip,
                        output logic hit, output logic ev, output logic [47:0] ev_addr);
    int n;
    int lat;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait got=%b want=1", req_ready);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (flip) begin
      write_policy   = ~write_policy;
      replace_policy = ~replace_policy;
    end
    @(negedge clk);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL resp_latency got=%0d want=2 addr=%h", lat, addr);
    end
    hit     = resp_hit;
    ev      = resp_evict;
    ev_addr = resp_evict_addr;
    if (flip) begin
      write_policy   = ~write_policy;
      replace_policy = ~replace_policy;
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, req_ready, resp_hit, resp_evict, resp_evict_addr} !== {4'b0100, 48'h0}) begin
      errors++;
      $display("FAIL post_resp got v=%b rdy=%b hit=%b ev=%b ea=%h want v=0 rdy=1 others 0",
               resp_valid, req_ready, resp_hit, resp_evict, resp_evict_addr);
    end
  endtask

  task automatic test_reset();
    logic [47:0] a;
    a = BaseA;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_hit, resp_evict} !== 4'b0000 || resp_evict_addr !== 48'h0
        || curr_tag !== 37'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b hit=%b ev=%b ea=%h tag=%h want all 0",
               req_ready, resp_valid, resp_hit, resp_evict, resp_evict_addr, curr_tag);
    end
    checks++;
    if ({num_reads, num_writes, num_hits, num_misses, num_writebacks} !== 160'h0) begin
      errors++;
      $display("FAIL reset_counters got r=%0d w=%0d h=%0d m=%0d wb=%0d want 0",
               num_reads, num_writes, num_hits, num_misses, num_writebacks);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b want=1 (a=%h)", req_ready, a);
    end
  endtask

  task automatic test_read_hit();
    logic h, e;
    logic [47:0] ea;
    logic [47:0] a;
    apply_reset();
    a = BaseA;
    do_req(1'b0, a, 1'b0, h, e, ea);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL read_first_miss got=%b want=0", h); end
    do_req(1'b0, a, 1'b0, h, e, ea);
    checks++;
    if (h !== 1'b1) begin errors++; $display("FAIL read_second_hit got=%b want=1", h); end
    checks++;
    if (curr_tag !== a[47:11]) begin
      errors++;
      $display("FAIL curr_tag got=%h want=%h", curr_tag, a[47:11]);
    end
    checks++;
    if (num_reads !== ex(2) || num_hits !== ex(1) || num_misses !== ex(1) || num_writes !== 0) begin
      errors++;
      $display("FAIL read_counts got r=%0d w=%0d h=%0d m=%0d want r=%0d w=0 h=%0d m=%0d",
               num_reads, num_writes, num_hits, num_misses, ex(2), ex(1), ex(1));
    end
  endtask

  task automatic test_lru();
    logic h, e;
    logic [47:0] ea;
    int seq [7] = '{0, 1, 2, 3, 0, 4, 1};
    bit exp_hit [7] = '{0, 0, 0, 0, 1, 0, 0};
    apply_reset();
    replace_policy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      do_req(1'b0, ak(seq[i]), 1'b0, h, e, ea);
      checks++;
      if (h !== exp_hit[i] || e !== 1'b0) begin
        errors++;
        $display("FAIL lru_step%0d got hit=%b ev=%b want hit=%b ev=0", i, h, e, exp_hit[i]);
      end
    end
    checks++;
    if (num_hits !== ex(1) || num_misses !== ex(6) || num_reads !== ex(7)) begin
      errors++;
      $display("FAIL lru_counts got h=%0d m=%0d r=%0d want h=%0d m=%0d r=%0d",
               num_hits, num_misses, num_reads, ex(1), ex(6), ex(7));
    end
  endtask

  task automatic test_fifo();
    logic h, e;
    logic [47:0] ea;
    int seq [8] = '{0, 1, 2, 3, 0, 4, 1, 0};
    bit exp_hit [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    apply_reset();
    replace_policy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      // The A4 request flips the policy inputs mid-flight; the latched FIFO must still apply.
      do_req(1'b0, ak(seq[i]), (i == 5), h, e, ea);
      checks++;
      if (h !== exp_hit[i]) begin
        errors++;
        $display("FAIL fifo_step%0d got hit=%b want hit=%b", i, h, exp_hit[i]);
      end
    end
    replace_policy = 1'b0;
  endtask

  task automatic test_wbwa();
    logic h, e;
    logic [47:0] ea;
    apply_reset();
    write_policy   = 1'b0;
    replace_policy = 1'b0;
    do_req(1'b1, ak(0), 1'b0, h, e, ea);
    checks++;
    if (h !== 1'b0 || e !== 1'b0) begin
      errors++;
      $display("FAIL wbwa_write_miss got hit=%b ev=%b want 0 0", h, e);
    end
    for (int k = 1; k <= 3; k++) begin
      do_req(1'b0, ak(k), 1'b0, h, e, ea);
      checks++;
      if (h !== 1'b0 || e !== 1'b0) begin
        errors++;
        $display("FAIL wbwa_fill%0d got hit=%b ev=%b want 0 0", k, h, e);
      end
    end
    do_req(1'b0, ak(4), 1'b0, h, e, ea);
    checks++;
    if (h !== 1'b0 || e !== 1'b1 || ea !== 48'h7fff_4938_2280) begin
      errors++;
      $display("FAIL wbwa_evict got hit=%b ev=%b ea=%h want hit=0 ev=1 ea=7fff49382280",
               h, e, ea);
    end
    checks++;
    if (num_writebacks !== ex(1) || num_writes !== ex(1) || num_reads !== ex(4)) begin
      errors++;
      $display("FAIL wbwa_counts got wb=%0d w=%0d r=%0d want wb=%0d w=%0d r=%0d",
               num_writebacks, num_writes, num_reads, ex(1), ex(1), ex(4));
    end
  endtask

  task automatic test_wtna();
    logic h, e;
    logic [47:0] ea;
    int ev_seen;
    apply_reset();
    write_policy   = 1'b1;
    replace_policy = 1'b0;
    ev_seen        = 0;
    do_req(1'b1, ak(0), 1'b0, h, e, ea);
    ev_seen += int'(e);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL wtna_write_miss got=%b want=0", h); end
    do_req(1'b0, ak(0), 1'b0, h, e, ea);
    ev_seen += int'(e);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL wtna_read_after got=%b want=0", h); end
    checks++;
    if (num_writes !== ex(1) || num_misses !== ex(2) || num_hits !== 0) begin
      errors++;
      $display("FAIL wtna_counts got w=%0d m=%0d h=%0d want w=%0d m=%0d h=0",
               num_writes, num_misses, num_hits, ex(1), ex(2));
    end
    // A write-through hit must leave the line clean, so its later eviction has no writeback.
    do_req(1'b1, ak(0), 1'b0, h, e, ea);
    ev_seen += int'(e);
    checks++;
    if (h !== 1'b1) begin errors++; $display("FAIL wtna_write_hit got=%b want=1", h); end
    for (int k = 1; k <= 4; k++) begin
      do_req(1'b0, ak(k), 1'b0, h, e, ea);
      ev_seen += int'(e);
    end
    checks++;
    if (ev_seen != 0 || num_writebacks !== 0) begin
      errors++;
      $display("FAIL wtna_no_evict got evicts=%0d wb=%0d want 0 0", ev_seen, num_writebacks);
    end
    write_policy = 1'b0;
  endtask

  task automatic test_abort();
    logic h, e;
    logic [47:0] ea;
    int seen;
    apply_reset();
    do_req(1'b0, BaseA, 1'b0, h, e, ea);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = BaseA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen      = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    seen += int'(resp_valid);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen += int'(resp_valid);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_resp got=%0d want=0", seen); end
    checks++;
    if ({num_reads, num_writes, num_hits, num_misses, num_writebacks} !== 160'h0
        || curr_tag !== 37'h0) begin
      errors++;
      $display("FAIL abort_clear got r=%0d h=%0d m=%0d tag=%h want all 0",
               num_reads, num_hits, num_misses, curr_tag);
    end
    do_req(1'b0, BaseA, 1'b0, h, e, ea);
    checks++;
    if (h !== 1'b0 || num_reads !== ex(1) || num_misses !== ex(1)) begin
      errors++;
      $display("FAIL abort_next_miss got hit=%b r=%0d m=%0d want hit=0 r=%0d m=%0d",
               h, num_reads, num_misses, ex(1), ex(1));
    end
  endtask

  initial begin
    reset          = 1'b0;
    write_policy   = 1'b0;
    replace_policy = 1'b0;
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_addr       = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_read_hit();
    test_lru();
    test_fifo();
    test_wbwa();
    test_wtna();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_set_assoc.md
# cache_set_assoc

Parametrised set-associative cache tag/state controller, successor to `cache_top`. It generalises address width, block size, set count and associativity. It adds a valid/ready request handshake, dirty-victim writeback reporting and runtime-selectable write and replacement policies. It sits between the trace-driven address source and the statistics/reporting logic, and holds tags and metadata only (no data array).

## Interface
- `ADDR_W`, 48: request address width.
- `BLOCK_BYTES`, 64: line size; power of 2, ≥2.
- `SETS`, 32: number of sets; power of 2, ≥2.
- `WAYS`, 4: associativity; power of 2, 2..16.
- `CNT_W`, 32: statistics counter width.
- Derived: `OFF_W=log2(BLOCK_BYTES)`, `IDX_W=log2(SETS)`, `TAG_W=ADDR_W-OFF_W-IDX_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `write_policy` in 1: 0 = write-back/write-allocate (WBWA), 1 = write-through/no-write-allocate (WTNA); sampled on accept.
- `replace_policy` in 1: 0 = LRU, 1 = FIFO; sampled on accept.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: byte address.
- `resp_valid` out 1: one-cycle result pulse.
- `resp_hit` out 1: request hit; valid with `resp_valid`.
- `resp_evict` out 1: dirty victim written back.
- `resp_evict_addr` out `ADDR_W`: `{victim_tag, set, OFF_W'b0}`.
- `curr_tag` out `TAG_W`: tag of the last accepted request.
- `num_reads`, `num_writes`, `num_hits`, `num_misses`, `num_writebacks` out `CNT_W` each: statistics counters.

## Operation
- Address split: offset `[OFF_W-1:0]`, set `[OFF_W+IDX_W-1:OFF_W]`, tag = upper `TAG_W` bits.
- Per line state: valid, dirty, tag. Per set: LRU ages (`log2(WAYS)` bits per way) and a FIFO pointer.
- FSM `IDLE → LOOKUP → RESP → IDLE`:
  - `req_ready=1` only in `IDLE`. Accept = `req_valid && req_ready`.
  - On accept, latch `req_we`, address and both policy bits, and update `curr_tag`.
  - In `LOOKUP`, compare the tag against all valid ways in parallel and select the victim.
- Victim selection:
  - Lowest-index invalid way if one exists.
  - Otherwise LRU picks the way with age `WAYS-1`; FIFO picks the way at the set's pointer.
- LRU update on any hit or fill of way w: ages below age[w] increment, then age[w]=0. Reset state: age[i]=i.
- FIFO pointer increments mod `WAYS` on fill only; hits do not change it.
- Read hit: touch replacement state only.
- Read miss: fill victim with valid=1, dirty=0.
- WBWA write hit: dirty=1. WBWA write miss: fill victim with dirty=1.
- WTNA write hit: touch replacement state, dirty unchanged. WTNA write miss: no allocation and no state change.
- Writeback: any fill whose victim is valid and dirty asserts `resp_evict` and counts one writeback, regardless of the current policy.
- Counters:
  - Read/write counters increment on accept.
  - Hit/miss counters increment in `RESP`.
  - All counters saturate at all-ones.
  - Invariant: hits+misses = reads+writes after each response.

## Timing
- Accept at edge N. `resp_valid` is high during cycle N+2, and all array/state updates commit at the end of that cycle. `req_ready` returns high in cycle N+3, giving a throughput of 1 request per 3 cycles.
- `resp_hit`, `resp_evict` and `resp_evict_addr` are meaningful only while `resp_valid=1`; they read 0 otherwise.
- Reset values: all counters 0, `curr_tag` 0, `resp_*` 0, `req_ready` 0 during reset and 1 on the first cycle after `reset` deasserts. All lines invalid and clean, FIFO pointers 0.
- Reset asserted in `LOOKUP` or `RESP` aborts the request: no `resp_valid`, no array update, and counters clear.
- Policy inputs changing mid-request have no effect; the latched values apply.
- Back-to-back same-set requests see the previous request's committed state.

## Configuration
- `CACHE_SET_ASSOC_STATS_EN` defined: the five counters are implemented as specified.
- Not defined: the counter registers are omitted and the counter outputs are tied to 0. Hit/miss/evict behaviour and `curr_tag` are unchanged.

## Test plan
Defaults apply (set stride 0x800); A=0x7fff493822b0 maps to set 10, and Ak = A + k·0x800.
- Read A, then read A again → first `resp_hit=0`, second `resp_hit=1`; reads=2, hits=1, misses=1, `resp_valid` 2 cycles after each accept.
- LRU: read A0..A3, read A0, read A4, read A1 → A4 evicts A1, so the final read misses. Totals: hits=1, misses=6.
- FIFO: same sequence → A4 evicts A0; a following read of A0 misses and a read of A1 hits.
- WBWA: write A0, then read A1..A4 under LRU → A4 response has `resp_evict=1`, `resp_evict_addr=0x7fff49382280`, writebacks=1.
- WTNA: write miss to A0, then read A0 → both `resp_hit=0`, `resp_evict` never 1, writes=1, misses=2.
- Pull `reset` low during `LOOKUP` → no `resp_valid`, all counters 0; the next read of A misses. With the macro undefined, all counters stay 0 throughout.
